fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 116 +++++++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory and registers IR/ID_PC for decode.
// Handles stalls with a one-word hold buffer and squashes in-flight words after taken branches.
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] IR,
  output logic [31:0] ID_PC
);

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] oaddr_q, oaddr_d;
  logic [31:0] hb_q, hb_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] pc_inc;
  logic [31:0] br_pc;

  assign pc_inc = pc_q + 32'd4;
  assign br_pc  = {br_target[31:2], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hb_d    = hb_q;
    ir_d    = ir_q;
    id_pc_d = id_pc_q;
    case (state_q)
      S_FETCH: begin
        if (br_taken) begin
          pc_d = br_pc;
          ir_d = 32'h0;
          if (imem_ready) begin
            id_pc_d = 32'h0;
          end else begin
            // Request still outstanding: its word must be dropped when it arrives.
            state_d = S_DISCARD;
          end
        end else if (stall) begin
          if (imem_ready) begin
            hb_d    = imem_rdata;
            pc_d    = pc_inc;
            state_d = S_HOLD;
          end
        end else if (imem_ready) begin
          ir_d    = imem_rdata;
          id_pc_d = pc_inc;
          pc_d    = pc_inc;
        end else begin
          ir_d = 32'h0;
        end
      end
      S_HOLD: begin
        if (br_taken) begin
          pc_d    = br_pc;
          ir_d    = 32'h0;
          id_pc_d = 32'h0;
          state_d = S_FETCH;
        end else if (!stall) begin
          // PC already advanced past the held word, so PC is its ID_PC.
          ir_d    = hb_q;
          id_pc_d = pc_q;
          state_d = S_FETCH;
        end
      end
      S_DISCARD: begin
        ir_d = 32'h0;
        if (br_taken) begin
          pc_d = br_pc;
        end else if (imem_ready) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    // The memory sees the old address until the discarded request completes.
    oaddr_d = (state_d == S_DISCARD) ? oaddr_q : pc_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= 32'h0;
      oaddr_q <= 32'h0;
      hb_q    <= 32'h0;
      ir_q    <= 32'h0;
      id_pc_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      oaddr_q <= oaddr_d;
      hb_q    <= hb_d;
      ir_q    <= ir_d;
      id_pc_q <= id_pc_d;
    end
  end

  assign imem_req  = !reset && (state_q != S_HOLD);
  assign imem_addr = oaddr_q;
  assign IR        = ir_q;
  assign ID_PC     = id_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stalls, branches, discard, wrap-around, reset in HOLD.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] IR;
  logic [31:0] ID_PC;

  int vectors = 0;
  int errors  = 0;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .IR         (IR),
    .ID_PC      (ID_PC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic [31:0] rd, input logic stl,
                       input logic br, input logic [31:0] tgt);
    imem_ready = rdy;
    imem_rdata = rd;
    stall      = stl;
    br_taken   = br;
    br_target  = tgt;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk("rst_ir", IR, 32'h0);
    chk("rst_idpc", ID_PC, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);

    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("post_rst_req", {31'h0, imem_req}, 32'h1);
    chk("post_rst_addr", imem_addr, 32'h0);

    // zero-wait stream
    drive(1'b1, 32'hE2811001, 1'b0, 1'b0, 32'h0);
    tick();
    chk("s1_ir", IR, 32'hE2811001);
    chk("s1_idpc", ID_PC, 32'h4);
    chk("s1_addr", imem_addr, 32'h4);
    drive(1'b1, 32'hE0822003, 1'b0, 1'b0, 32'h0);
    tick();
    chk("s2_ir", IR, 32'hE0822003);
    chk("s2_idpc", ID_PC, 32'h8);
    chk("s2_addr", imem_addr, 32'h8);

    // word at PC 8 returns while stalled
    drive(1'b1, 32'h11110008, 1'b1, 1'b0, 32'h0);
    tick();
    chk("st1_ir", IR, 32'hE0822003);
    chk("st1_idpc", ID_PC, 32'h8);
    chk("st1_req", {31'h0, imem_req}, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    chk("st2_ir", IR, 32'hE0822003);
    chk("st2_req", {31'h0, imem_req}, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("st3_ir", IR, 32'h11110008);
    chk("st3_idpc", ID_PC, 32'hC);
    chk("st3_req", {31'h0, imem_req}, 32'h1);
    chk("st3_addr", imem_addr, 32'hC);

    // wait with stall holds IR; wait without stall inserts a bubble
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    chk("wst_ir", IR, 32'h11110008);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("bub_ir", IR, 32'h0);
    chk("bub_idpc", ID_PC, 32'hC);
    chk("bub_addr", imem_addr, 32'hC);

    // branch beats stall; low target bits ignored
    drive(1'b1, 32'hBAD0BAD0, 1'b1, 1'b1, 32'h00000101);
    tick();
    chk("bs_ir", IR, 32'h0);
    chk("bs_idpc", ID_PC, 32'h0);
    chk("bs_addr", imem_addr, 32'h100);
    drive(1'b1, 32'hE3A00001, 1'b0, 1'b0, 32'h0);
    tick();
    chk("bs2_ir", IR, 32'hE3A00001);
    chk("bs2_idpc", ID_PC, 32'h104);
    chk("bs2_addr", imem_addr, 32'h104);

    // branch while waiting on 0x10
    drive(1'b1, 32'hBAD0BAD0, 1'b0, 1'b1, 32'h10);
    tick();
    chk("bw0_addr", imem_addr, 32'h10);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
    tick();
    chk("bw1_ir", IR, 32'h0);
    chk("bw1_addr", imem_addr, 32'h10);
    chk("bw1_req", {31'h0, imem_req}, 32'h1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("bw2_ir", IR, 32'h0);
    chk("bw2_addr", imem_addr, 32'h10);
    drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    tick();
    chk("bw3_ir", IR, 32'h0);
    chk("bw3_addr", imem_addr, 32'h40);
    drive(1'b1, 32'hE1A00000, 1'b0, 1'b0, 32'h0);
    tick();
    chk("bw4_ir", IR, 32'hE1A00000);
    chk("bw4_idpc", ID_PC, 32'h44);

    // wrap-around at the top of memory
    drive(1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFC);
    tick();
    chk("wr0_addr", imem_addr, 32'hFFFFFFFC);
    drive(1'b1, 32'hE0000000, 1'b0, 1'b0, 32'h0);
    tick();
    chk("wr1_ir", IR, 32'hE0000000);
    chk("wr1_idpc", ID_PC, 32'h0);
    chk("wr1_addr", imem_addr, 32'h0);

    // reset while holding a word
    drive(1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0);
    tick();
    chk("rh0_req", {31'h0, imem_req}, 32'h0);
    chk("rh0_ir", IR, 32'hE0000000);
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    chk("rh1_ir", IR, 32'h0);
    chk("rh1_idpc", ID_PC, 32'h0);
    chk("rh1_addr", imem_addr, 32'h0);
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("rh2_req", {31'h0, imem_req}, 32'h1);
    tick();
    chk("rh2_ir", IR, 32'h0);
    chk("rh2_addr", imem_addr, 32'h0);
    drive(1'b1, 32'h0A0B0C0C, 1'b0, 1'b0, 32'h0);
    tick();
    chk("rh3_ir", IR, 32'h0A0B0C0C);
    chk("rh3_idpc", ID_PC, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
